// File: rtl/dw02_tree_accum_pkg.sv
// Shared types and width helpers for the DW02_tree frame accumulator controller.
package dw02_tree_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The tree must hold the exact sum of NUM_INPUTS full-scale operands.
    function automatic int tree_width_f(input int num_inputs, input int input_width);
        return input_width + $clog2(num_inputs);
    endfunction

    function automatic int cnt_width_f(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    localparam int TREE_WIDTH = tree_width_f(8, 8);
    localparam int CNT_WIDTH  = cnt_width_f(16);

endpackage

// File: rtl/dw02_tree_accum_ctrl_beat_sum.sv
// Beat reduction: zero-extends each operand and reduces the vector to a
// carry-save pair (OUT0, OUT1) whose modular sum is the exact beat total.
module dw02_tree_beat_sum #(
    parameter int NUM_INPUTS  = 8,
    parameter int INPUT_WIDTH = 8,
    parameter int TREE_WIDTH  = 11,
    parameter int VERIF_EN    = 1
) (
    input  logic [NUM_INPUTS*INPUT_WIDTH-1:0] in_data,
    output logic [TREE_WIDTH-1:0]             out0,
    output logic [TREE_WIDTH-1:0]             out1
);

    logic [TREE_WIDTH-1:0] ops [NUM_INPUTS];

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            ops[i] = {{(TREE_WIDTH-INPUT_WIDTH){1'b0}}, in_data[i*INPUT_WIDTH +: INPUT_WIDTH]};
        end
    end

    if (VERIF_EN != 0) begin : g_csa
        // Chain of 3:2 compressors, matching the split output form of DW02_tree.
        always_comb begin
            logic [TREE_WIDTH-1:0] s_v;
            logic [TREE_WIDTH-1:0] c_v;
            logic [TREE_WIDTH-1:0] t_v;
            s_v = ops[0];
            c_v = ops[1];
            t_v = '0;
            for (int i = 2; i < NUM_INPUTS; i++) begin
                t_v = s_v ^ c_v ^ ops[i];
                c_v = ((s_v & c_v) | (s_v & ops[i]) | (c_v & ops[i])) << 1;
                s_v = t_v;
            end
            out0 = s_v;
            out1 = c_v;
        end
    end else begin : g_resolved
        always_comb begin
            out0 = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                out0 = out0 + ops[i];
            end
            out1 = '0;
        end
    end

endmodule

// File: rtl/dw02_tree_accum_ctrl.sv
// Frame accumulator around a carry-save adder tree: valid/ready operand beats in,
// one registered frame total out per frame.
module dw02_tree_accum_ctrl
    import dw02_tree_accum_pkg::*;
#(
    parameter int NUM_INPUTS  = 8,
    parameter int INPUT_WIDTH = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int MAX_BEATS   = 16,
    parameter int VERIF_EN    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_INPUTS*INPUT_WIDTH-1:0] in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ACC_WIDTH-1:0]              out_sum,
    output logic [$clog2(MAX_BEATS+1)-1:0]    out_beats,
    output logic                              out_ovf,
    output logic                              out_trunc,
    output logic                              busy
);

    localparam int TREE_WIDTH = tree_width_f(NUM_INPUTS, INPUT_WIDTH);
    localparam int CNT_WIDTH  = cnt_width_f(MAX_BEATS);

    state_e                state_q, state_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [TREE_WIDTH-1:0] s1_out0_q, s1_out0_d;
    logic [TREE_WIDTH-1:0] s1_out1_q, s1_out1_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  trunc_q, trunc_d;

    logic [TREE_WIDTH-1:0] tree_out0, tree_out1;
    logic [TREE_WIDTH-1:0] beat_sum;
    logic [ACC_WIDTH:0]    acc_sum;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  cnt_at_max;
    logic                  accept;

    dw02_tree_beat_sum #(
        .NUM_INPUTS  (NUM_INPUTS),
        .INPUT_WIDTH (INPUT_WIDTH),
        .TREE_WIDTH  (TREE_WIDTH),
        .VERIF_EN    (VERIF_EN)
    ) u_beat_sum (
        .in_data (in_data),
        .out0    (tree_out0),
        .out1    (tree_out1)
    );

    // Gated by rst so nothing is accepted while the block is held in reset.
    assign in_ready   = ~rst & ((state_q == IDLE) || (state_q == ACCUM));
    assign accept     = in_valid & in_ready;
    assign beat_sum   = s1_out0_q + s1_out1_q;
    assign acc_sum    = {1'b0, acc_q} + {{(ACC_WIDTH+1-TREE_WIDTH){1'b0}}, beat_sum};
    assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
    assign cnt_at_max = (cnt_inc == CNT_WIDTH'(MAX_BEATS));

    always_comb begin
        state_d    = state_q;
        s1_valid_d = accept;
        s1_out0_d  = accept ? tree_out0 : s1_out0_q;
        s1_out1_d  = accept ? tree_out1 : s1_out1_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        trunc_d    = trunc_q;

        if (s1_valid_q) begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | acc_sum[ACC_WIDTH];
        end

        case (state_q)
            IDLE, ACCUM: begin
                // cnt_q is zero in IDLE, so the same increment starts a frame.
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (in_last || cnt_at_max) begin
                        trunc_d = ~in_last;
                        state_d = FLUSH;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_out0_q  <= '0;
            s1_out1_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_out0_q  <= s1_out0_d;
            s1_out1_q  <= s1_out1_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            trunc_q    <= trunc_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_beats = cnt_q;
    assign out_ovf   = ovf_q;
    assign out_trunc = trunc_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dw02_tree_accum_ctrl.sv
// Directed bench for the frame accumulator: default instance plus a 12-bit
// accumulator instance for the overflow case.
module tb_dw02_tree_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid, out_ovf, out_trunc, busy;
    logic [23:0] out_sum;
    logic [4:0]  out_beats;

    logic        v2_in_valid = 1'b0, v2_in_last = 1'b0, v2_out_ready = 1'b0;
    logic [63:0] v2_in_data = '0;
    logic        v2_in_ready, v2_out_valid, v2_out_ovf, v2_out_trunc, v2_busy;
    logic [11:0] v2_out_sum;
    logic [4:0]  v2_out_beats;

    int checks = 0;
    int passed = 0;

    dw02_tree_accum_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_beats(out_beats), .out_ovf(out_ovf), .out_trunc(out_trunc), .busy(busy)
    );

    dw02_tree_accum_ctrl #(.ACC_WIDTH(12)) dut12 (
        .clk(clk), .rst(rst),
        .in_valid(v2_in_valid), .in_ready(v2_in_ready), .in_data(v2_in_data), .in_last(v2_in_last),
        .out_valid(v2_out_valid), .out_ready(v2_out_ready), .out_sum(v2_out_sum),
        .out_beats(v2_out_beats), .out_ovf(v2_out_ovf), .out_trunc(v2_out_trunc), .busy(v2_busy)
    );

    function automatic logic [63:0] fill(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
        checks++; if (out_sum !== 24'd0 || out_beats !== 5'd0) $display("FAIL reset_sum_beats got %0d/%0d want 0/0", out_sum, out_beats); else passed++;
        checks++; if (out_ovf !== 1'b0 || out_trunc !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags got ovf=%0b trunc=%0b busy=%0b want 0", out_ovf, out_trunc, busy); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %0b want 1", in_ready); else passed++;
    endtask

    task automatic test_single_beat();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(i + 1);
        @(negedge clk);
        in_data = d; in_valid = 1'b1; in_last = 1'b1;
        checks++; if (in_ready !== 1'b1) $display("FAIL single_ready got %0b want 1", in_ready); else passed++;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL single_t1 got valid=%0b busy=%0b want 0/1", out_valid, busy); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) $display("FAIL single_latency got valid=%0b want 1", out_valid); else passed++;
        checks++; if (out_sum !== 24'd36 || out_beats !== 5'd1) $display("FAIL single_sum got %0d/%0d want 36/1", out_sum, out_beats); else passed++;
        checks++; if (out_ovf !== 1'b0 || out_trunc !== 1'b0) $display("FAIL single_flags got ovf=%0b trunc=%0b want 0/0", out_ovf, out_trunc); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL single_handshake got valid=%0b ready=%0b want 0/1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_data = fill(8'hFF); in_valid = 1'b1; in_last = (i == 3);
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready beat %0d got %0b want 1", i, in_ready); else passed++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_flush_ready got %0b want 0", in_ready); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL b2b_done got valid=%0b ready=%0b want 1/0", out_valid, in_ready); else passed++;
        checks++; if (out_sum !== 24'd8160 || out_beats !== 5'd4) $display("FAIL b2b_sum got %0d/%0d want 8160/4", out_sum, out_beats); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v2_in_data = fill(8'hFF); v2_in_valid = 1'b1; v2_in_last = (i == 2);
        end
        @(negedge clk);
        v2_in_valid = 1'b0; v2_in_last = 1'b0;
        @(negedge clk);
        checks++; if (v2_out_valid !== 1'b1) $display("FAIL ovf_valid got %0b want 1", v2_out_valid); else passed++;
        checks++; if (v2_out_sum !== 12'd2024 || v2_out_beats !== 5'd3) $display("FAIL ovf_sum got %0d/%0d want 2024/3", v2_out_sum, v2_out_beats); else passed++;
        checks++; if (v2_out_ovf !== 1'b1 || v2_out_trunc !== 1'b0) $display("FAIL ovf_flag got ovf=%0b trunc=%0b want 1/0", v2_out_ovf, v2_out_trunc); else passed++;
        v2_out_ready = 1'b1;
        @(negedge clk);
        v2_out_ready = 1'b0;
        checks++; if (v2_out_ovf !== 1'b0 || v2_out_sum !== 12'd0) $display("FAIL ovf_clear got ovf=%0b sum=%0d want 0/0", v2_out_ovf, v2_out_sum); else passed++;
    endtask

    task automatic test_truncation();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_data = fill(8'h01); in_valid = 1'b1; in_last = 1'b0;
        end
        @(negedge clk);
        in_data = fill(8'h02); in_valid = 1'b1; in_last = 1'b1;
        checks++; if (in_ready !== 1'b0) $display("FAIL trunc_flush_ready got %0b want 0", in_ready); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL trunc_done got valid=%0b ready=%0b want 1/0", out_valid, in_ready); else passed++;
        checks++; if (out_sum !== 24'd128 || out_beats !== 5'd16) $display("FAIL trunc_sum got %0d/%0d want 128/16", out_sum, out_beats); else passed++;
        checks++; if (out_trunc !== 1'b1 || out_ovf !== 1'b0) $display("FAIL trunc_flag got trunc=%0b ovf=%0b want 1/0", out_trunc, out_ovf); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_beats !== 5'd0) $display("FAIL trunc_idle got valid=%0b ready=%0b beats=%0d want 0/1/0", out_valid, in_ready, out_beats); else passed++;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) $display("FAIL trunc_next_valid got %0b want 1", out_valid); else passed++;
        checks++; if (out_sum !== 24'd16 || out_beats !== 5'd1 || out_trunc !== 1'b0) $display("FAIL trunc_next_sum got %0d/%0d trunc=%0b want 16/1/0", out_sum, out_beats, out_trunc); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_data = fill(8'h03); in_valid = 1'b1; in_last = (i == 1);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL bp_hold cycle %0d got valid=%0b ready=%0b want 1/0", i, out_valid, in_ready); else passed++;
            checks++; if (out_sum !== 24'd48 || out_beats !== 5'd2) $display("FAIL bp_stable cycle %0d got %0d/%0d want 48/2", i, out_sum, out_beats); else passed++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_release got valid=%0b ready=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy); else passed++;
        in_data = fill(8'h01); in_valid = 1'b1; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 24'd8 || out_beats !== 5'd1) $display("FAIL bp_next got valid=%0b sum=%0d beats=%0d want 1/8/1", out_valid, out_sum, out_beats); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_data = fill(8'h05); in_valid = 1'b1; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_sum !== 24'd0 || out_beats !== 5'd0) $display("FAIL midrst_outputs got valid=%0b sum=%0d beats=%0d want 0/0/0", out_valid, out_sum, out_beats); else passed++;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL midrst_busy got busy=%0b ready=%0b want 0/0", busy, in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_quiet cycle %0d got valid=%0b busy=%0b want 0/0", i, out_valid, busy); else passed++;
        end
        in_data = fill(8'h02); in_valid = 1'b1; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 24'd16 || out_beats !== 5'd1) $display("FAIL midrst_next got valid=%0b sum=%0d beats=%0d want 1/16/1", out_valid, out_sum, out_beats); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_truncation();
        test_backpressure();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
